// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder datapath.
//   add_mode_t : arithmetic mode encoding carried on the i_mode port
//   op_ctrl_t  : per-operation control derived from the mode
//   mode_ctrl  : gives the B-operand inversion flag and the carry-in for a mode
package adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_ADDC = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_SUBB = 2'b11
    } add_mode_t;

    typedef struct packed {
        logic invert_b;  // B' = ~B when set, B otherwise
        logic cin;       // carry into the least significant segment
    } op_ctrl_t;

    // Subtraction is A + ~B + 1. For SUBB an incoming borrow (c_in = 1) removes the +1.
    function automatic op_ctrl_t mode_ctrl(input add_mode_t mode, input logic c_in);
        op_ctrl_t ctrl;
        ctrl = '0;
        case (mode)
            MODE_ADD:  begin ctrl.invert_b = 1'b0; ctrl.cin = 1'b0;  end
            MODE_ADDC: begin ctrl.invert_b = 1'b0; ctrl.cin = c_in;  end
            MODE_SUB:  begin ctrl.invert_b = 1'b1; ctrl.cin = 1'b1;  end
            MODE_SUBB: begin ctrl.invert_b = 1'b1; ctrl.cin = ~c_in; end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One SEG_W-bit slice of the carry-segmented adder.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : shared pipeline advance enable
//   i_a, i_b     : segment operands (B already conditioned for the mode)
//   i_cin        : carry from the previous segment
//   o_sum        : registered segment sum
//   o_cout       : registered carry out of the segment
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [SEG_W-1:0] i_a,
    input  logic [SEG_W-1:0] i_b,
    input  logic             i_cin,
    output logic [SEG_W-1:0] o_sum,
    output logic             o_cout
);

    logic [SEG_W:0]   w_total;
    logic [SEG_W-1:0] r_sum;
    logic             r_cout;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{SEG_W{1'b0}}, i_cin};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (i_en) begin
            r_sum  <= w_total[SEG_W-1:0];
            r_cout <= w_total[SEG_W];
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined add/subtract with valid/ready handshake on both sides.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_in_valid / o_in_ready  : operand handshake (o_in_ready = pipeline advance)
//   i_a, i_b, i_c_in, i_mode : operands, carry/borrow in, mode (ADD/ADDC/SUB/SUBB)
//   o_out_valid / i_out_ready: result handshake
//   o_sum, o_c_out           : result and carry out (1 = no borrow for subtraction)
//   o_overflow               : two's-complement signed overflow
// Latency is NSEG+1 cycles: input register, NSEG segment stages, output register.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    input  logic [1:0]       i_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c_out,
    output logic             o_overflow
);

    localparam int NSEG = WIDTH / SEG_W;

    logic             w_advance;
    logic             w_accept;
    op_ctrl_t         w_ctrl;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_ovf_next;

    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_b0;
    logic             r_cin0;
    logic [NSEG:0]    r_valid;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_out_valid;

    // Single global stall: every stage moves only when the output slot is free or being taken.
    assign w_advance = !r_out_valid || i_out_ready;
    assign w_accept  = i_in_valid && w_advance;
    assign w_ctrl    = mode_ctrl(add_mode_t'(i_mode), i_c_in);
    assign w_b_eff   = w_ctrl.invert_b ? ~i_b : i_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a0   <= '0;
            r_b0   <= '0;
            r_cin0 <= 1'b0;
        end else if (w_accept) begin
            r_a0   <= i_a;
            r_b0   <= w_b_eff;
            r_cin0 <= w_ctrl.cin;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid <= {r_valid[NSEG-1:0], i_in_valid};
        end
    end

    // Stage k adds segment k-1. w_a_rem/w_b_rem hold only the operand bits not yet
    // consumed (bit 0 = LSB of segment k-1); w_sum holds the k completed segments.
    for (genvar k = 1; k <= NSEG; k++) begin : g_stage
        logic [WIDTH-(k-1)*SEG_W-1:0] w_a_rem;
        logic [WIDTH-(k-1)*SEG_W-1:0] w_b_rem;
        logic                         w_cin;
        logic [SEG_W-1:0]             w_seg_sum;
        logic                         w_cout;
        logic [k*SEG_W-1:0]           w_sum;

        if (k == 1) begin : g_first
            assign w_a_rem = r_a0;
            assign w_b_rem = r_b0;
            assign w_cin   = r_cin0;
            assign w_sum   = w_seg_sum;
        end else begin : g_skew
            logic [WIDTH-(k-1)*SEG_W-1:0] r_a_rem;
            logic [WIDTH-(k-1)*SEG_W-1:0] r_b_rem;
            logic [(k-1)*SEG_W-1:0]       r_sum_lo;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_a_rem  <= '0;
                    r_b_rem  <= '0;
                    r_sum_lo <= '0;
                end else if (w_advance) begin
                    r_a_rem  <= g_stage[k-1].w_a_rem[WIDTH-(k-2)*SEG_W-1:SEG_W];
                    r_b_rem  <= g_stage[k-1].w_b_rem[WIDTH-(k-2)*SEG_W-1:SEG_W];
                    r_sum_lo <= g_stage[k-1].w_sum;
                end
            end

            assign w_a_rem = r_a_rem;
            assign w_b_rem = r_b_rem;
            assign w_cin   = g_stage[k-1].w_cout;
            assign w_sum   = {w_seg_sum, r_sum_lo};
        end

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (w_advance),
            .i_a    (w_a_rem[SEG_W-1:0]),
            .i_b    (w_b_rem[SEG_W-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_seg_sum),
            .o_cout (w_cout)
        );
    end

    // Operand sign bits enter the last segment; keep them aligned with its registered sum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_advance) begin
            r_a_msb <= g_stage[NSEG].w_a_rem[SEG_W-1];
            r_b_msb <= g_stage[NSEG].w_b_rem[SEG_W-1];
        end
    end

    assign w_ovf_next = (r_a_msb == r_b_msb) && (g_stage[NSEG].w_sum[WIDTH-1] != r_a_msb);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_valid[NSEG];
            r_sum       <= g_stage[NSEG].w_sum;
            r_c_out     <= g_stage[NSEG].w_cout;
            r_ovf       <= w_ovf_next;
        end
    end

    assign o_in_ready  = w_advance;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_c_out     = r_c_out;
    assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT: WIDTH=16, SEG_W=4
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic        in_cin = 1'b0;
    logic [1:0]  in_mode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_c, out_ovf;

    pipelined_adder #(.WIDTH(16), .SEG_W(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(in_a), .i_b(in_b), .i_c_in(in_cin), .i_mode(in_mode),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_sum(out_sum), .o_c_out(out_c), .o_overflow(out_ovf)
    );

    // corner DUT: WIDTH=8, SEG_W=8
    logic       c8_valid = 1'b0, c8_ready, c8_ovalid, c8_oready = 1'b1;
    logic [7:0] c8_a = '0, c8_b = '0, c8_sum;
    logic       c8_cin = 1'b0, c8_c, c8_ovf;
    logic [1:0] c8_mode = 2'b00;

    pipelined_adder #(.WIDTH(8), .SEG_W(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(c8_valid), .o_in_ready(c8_ready),
        .i_a(c8_a), .i_b(c8_b), .i_c_in(c8_cin), .i_mode(c8_mode),
        .o_out_valid(c8_ovalid), .i_out_ready(c8_oready),
        .o_sum(c8_sum), .o_c_out(c8_c), .o_overflow(c8_ovf)
    );

    // corner DUT: WIDTH=32, SEG_W=4
    logic        c32_valid = 1'b0, c32_ready, c32_ovalid, c32_oready = 1'b1;
    logic [31:0] c32_a = '0, c32_b = '0, c32_sum;
    logic        c32_cin = 1'b0, c32_c, c32_ovf;
    logic [1:0]  c32_mode = 2'b00;

    pipelined_adder #(.WIDTH(32), .SEG_W(4)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(c32_valid), .o_in_ready(c32_ready),
        .i_a(c32_a), .i_b(c32_b), .i_c_in(c32_cin), .i_mode(c32_mode),
        .o_out_valid(c32_ovalid), .i_out_ready(c32_oready),
        .o_sum(c32_sum), .o_c_out(c32_c), .o_overflow(c32_ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: {ovf, c_out, sum} from {C,SUM} = A + B' + cin.
    function automatic logic [17:0] ref16(input logic [1:0] m, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        logic [15:0] bp;
        logic        ci;
        logic [16:0] t;
        logic        ov;
        bp = (m[1]) ? ~b : b;
        case (m)
            2'b00:   ci = 1'b0;
            2'b01:   ci = c;
            2'b10:   ci = 1'b1;
            default: ci = ~c;
        endcase
        t  = {1'b0, a} + {1'b0, bp} + {16'd0, ci};
        ov = (a[15] == bp[15]) && (t[15] != a[15]);
        return {ov, t[16], t[15:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          cyc_cnt = 0;
    int          n_take = 0, first_take = 0, last_take = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("stream_extra_result", 1, 0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("stream_result", {out_ovf, out_c, out_sum}, e);
            end
            if (n_take == 0) first_take = cyc_cnt;
            last_take = cyc_cnt;
            n_take++;
        end
    end

    task automatic send(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
        bit acc;
        int g;
        acc = 1'b0;
        g = 0;
        in_mode = m; in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        while (!acc && g < 100) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back(ref16(m, a, b, c));
            @(posedge clk); #1;
            g++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       nm;
        logic [1:0]  mode;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] sum;
        logic        c, ovf;
    } vec_t;

    vec_t vt[13];

    task automatic run_vec(input vec_t v);
        int cyc;
        in_mode = v.mode; in_a = v.a; in_b = v.b; in_cin = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!out_valid && cyc < 20);
        chk({v.nm, "_latency"}, cyc, 5);
        chk({v.nm, "_sum"}, out_sum, v.sum);
        chk({v.nm, "_cout"}, out_c, v.c);
        chk({v.nm, "_ovf"}, out_ovf, v.ovf);
    endtask

    task automatic run8(input string nm, input logic [1:0] m, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic [7:0] es,
                        input logic ec, input logic eo);
        int cyc;
        c8_mode = m; c8_a = a; c8_b = b; c8_cin = c; c8_valid = 1'b1;
        @(posedge clk); #1;
        c8_valid = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!c8_ovalid && cyc < 20);
        chk({nm, "_latency"}, cyc, 2);
        chk({nm, "_result"}, {c8_ovf, c8_c, c8_sum}, {eo, ec, es});
    endtask

    task automatic run32(input string nm, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic [31:0] es,
                         input logic ec, input logic eo);
        int cyc;
        c32_mode = m; c32_a = a; c32_b = b; c32_cin = c; c32_valid = 1'b1;
        @(posedge clk); #1;
        c32_valid = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!c32_ovalid && cyc < 30);
        chk({nm, "_latency"}, cyc, 9);
        chk({nm, "_result"}, {c32_ovf, c32_c, c32_sum}, {eo, ec, es});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hs;
        logic [2:0]  hf;
        int          seen;

        //              name        mode   a        b        cin   sum      c     ovf
        vt[0]  = '{"add_wrap",   2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{"sub_ovf",    2'b10, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vt[2]  = '{"subb_brw",   2'b11, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[3]  = '{"addc_ovf",   2'b01, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vt[4]  = '{"add_plain",  2'b00, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[5]  = '{"addc_c0",    2'b01, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vt[6]  = '{"sub_zero",   2'b10, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{"sub_neg",    2'b10, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vt[8]  = '{"subb_nobrw", 2'b11, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b1, 1'b0};
        vt[9]  = '{"add_posovf", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[10] = '{"add_negovf", 2'b00, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[11] = '{"add_ign_cin",2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0};
        vt[12] = '{"add_segcry", 2'b00, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {out_valid, out_ovf, out_c, out_sum}, '0);
        chk("reset_outputs8", {c8_ovalid, c8_ovf, c8_c, c8_sum}, '0);
        chk("reset_outputs32", {c32_ovalid, c32_ovf, c32_c, c32_sum}, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_reset", in_ready, 1);

        for (int i = 0; i < 13; i++) run_vec(vt[i]);
        @(posedge clk); #1;

        // back-to-back stream, one result per cycle
        mon_en = 1'b1;
        n_take = 0;
        for (int i = 0; i < 100; i++)
            send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom));
        drain();
        chk("stream_count", n_take, 100);
        chk("stream_full_rate", last_take - first_take, 99);

        // backpressure mid-stream
        n_take = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom));
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                hs = out_sum;
                hf = {out_valid, out_c, out_ovf};
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_hold", {out_valid, out_c, out_ovf, out_sum}, {hf, hs});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", n_take, 20);

        // reset with operations in flight
        mon_en = 1'b0;
        send(2'b00, 16'h1111, 16'h2222, 1'b0);
        send(2'b10, 16'h3333, 16'h1111, 1'b0);
        send(2'b01, 16'h0F0F, 16'h0101, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_outputs", {out_valid, out_sum}, '0);
        rst = 1'b0;
        exp_q.delete();
        seen = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midreset_no_stale", seen, 0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        n_take = 0;
        send(2'b00, 16'hABCD, 16'h1111, 1'b0);
        send(2'b11, 16'h1000, 16'h0001, 1'b1);
        send(2'b01, 16'hFFFF, 16'h0000, 1'b1);
        drain();
        chk("post_reset_count", n_take, 3);
        mon_en = 1'b0;

        // NSEG = 1 and NSEG = 8 configurations
        run8("w8_add_wrap", 2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("w8_sub_ovf",  2'b10, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        run8("w8_addc_ovf", 2'b01, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        run8("w8_subb",     2'b11, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        run32("w32_add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run32("w32_sub_ovf",  2'b10, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run32("w32_addc",     2'b01, 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0);
        run32("w32_subb",     2'b11, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
